// File: rtl/uart_tx_frame_engine_pkg.sv
// UartGlobalPkg: shared definitions for the UART transmit path.
//
// Contents:
//   uartTxState_t    frame-level FSM states RESET/IDLE/STARTBIT/DATA/PARITYBIT/STOPBIT.
//                    A single DATA state with a bit counter stands in for one state per data bit.
//   START_BIT        line level of the start bit.
//   STOP_BIT         line level of a stop bit and of the idle line.
//   OVERSAMPLING_13  supported oversample factor.
//   OVERSAMPLING_16  supported oversample factor.
//   MIN_DATA_BITS    smallest data-bit count the engine sends.
//   clampDataBits()  maps a requested data-bit count onto [MIN_DATA_BITS, maxBits].
package UartGlobalPkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    IDLE      = 3'd1,
    STARTBIT  = 3'd2,
    DATA      = 3'd3,
    PARITYBIT = 3'd4,
    STOPBIT   = 3'd5
  } uartTxState_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [4:0] OVERSAMPLING_13 = 5'd13;
  localparam logic [4:0] OVERSAMPLING_16 = 5'd16;

  localparam logic [3:0] MIN_DATA_BITS = 4'd5;

  function automatic logic [3:0] clampDataBits(input logic [3:0] req,
                                               input logic [3:0] maxBits);
    if (req < MIN_DATA_BITS) begin
      return MIN_DATA_BITS;
    end else if (req > maxBits) begin
      return maxBits;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/uart_tx_frame_engine_if.sv
// uart_tx_frame_engine_if: word-level handshake into the UART transmitter.
//
// Signals:
//   txValid  the producer offers txData.
//   txReady  the engine can take a word.
//   txData   word to send. The LSB goes out first.
//
// Handshake: a word transfers on every rising clk edge where txValid and txReady are both high.
// The producer holds txValid and txData stable until that edge.
// txReady never depends combinationally on txValid.
//
// Modports:
//   master  the producer.
//   slave   the engine.
interface uart_tx_frame_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  txValid;
  logic                  txReady;
  logic [DATA_WIDTH-1:0] txData;

  modport master (output txValid, output txData, input txReady);
  modport slave  (input txValid, input txData, output txReady);
endinterface

// File: rtl/uart_tx_frame_engine_baud_tick_gen.sv
// uart_baud_tick_gen: turns the baud divisor and oversample factor into one bitTick per bit period.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset.
//   clear         restarts the period. It is pulsed on the edge that starts a frame,
//                 so every bit period is exact.
//   enable        counts only while a frame is on the line.
//   divisor       clk cycles per oversample tick. 0 behaves as 1.
//   overSampling  oversample ticks per bit. 0 behaves as 1.
//   bitTick       high during the final clk cycle of each bit period.
module uart_baud_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [4:0]           overSampling,
  output logic                 bitTick
);

  logic [DIV_WIDTH-1:0] divCnt;
  logic [DIV_WIDTH-1:0] divLast;
  logic [4:0]           tickCnt;
  logic [4:0]           tickLast;
  logic                 divWrap;
  logic                 tickWrap;

  always_comb begin
    divLast  = (divisor == '0) ? '0 : divisor - DIV_WIDTH'(1);
    tickLast = (overSampling == 5'd0) ? 5'd0 : overSampling - 5'd1;
    // The >= comparisons keep the counters from running away if the last value moves underneath them.
    divWrap  = (divCnt >= divLast);
    tickWrap = (tickCnt >= tickLast);
    bitTick  = enable && divWrap && tickWrap;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      divCnt  <= '0;
      tickCnt <= '0;
    end else if (enable) begin
      if (divWrap) begin
        divCnt  <= '0;
        tickCnt <= tickWrap ? 5'd0 : tickCnt + 5'd1;
      end else begin
        divCnt <= divCnt + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame_engine.sv
// uart_tx_frame_engine: UART transmitter with run-time frame shape and a one-word holding buffer.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset.
//   txIf             slave side of the word handshake (txValid/txReady/txData).
//   cfgDataBits      data bits per frame. Clamped to 5..DATA_WIDTH.
//   cfgParityEnable  insert a parity bit after the data bits.
//   cfgParityOdd     0 selects even parity, 1 selects odd parity.
//   cfgTwoStop       0 selects one stop bit, 1 selects two stop bits.
//   cfgBaudDivisor   clk cycles per oversample tick. 0 behaves as 1.
//   cfgOverSampling  oversample ticks per bit (13 or 16).
//   tx               serial line. It idles high.
//   busy             a frame is on the line.
//   frameDone        one-cycle pulse during the last cycle of the last stop bit.
//   stateDbg         current FSM state.
//
// Optional build macro:
//   UART_TX_ERROR_INJECTION_EN
//     Adds the inputs injectParityError, injectFramingError and injectBreak.
//     All three are captured with the config at frame start.
//
// Timing:
//   The FSM decides line values one cycle ahead. tx, busy and frameDone are registered copies of
//   those decisions, so an accept at edge N puts the start bit on tx from edge N+1.
//   All cfg* inputs are latched on the edge that starts a frame.
//   DATA_WIDTH must not exceed 15, because the data-bit count is 4 bits wide.
module uart_tx_frame_engine
  import UartGlobalPkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_frame_engine_if.slave txIf,
  input  logic [3:0]           cfgDataBits,
  input  logic                 cfgParityEnable,
  input  logic                 cfgParityOdd,
  input  logic                 cfgTwoStop,
  input  logic [DIV_WIDTH-1:0] cfgBaudDivisor,
  input  logic [4:0]           cfgOverSampling,
`ifdef UART_TX_ERROR_INJECTION_EN
  input  logic                 injectParityError,
  input  logic                 injectFramingError,
  input  logic                 injectBreak,
`endif
  output logic                 tx,
  output logic                 busy,
  output logic                 frameDone,
  output uartTxState_t         stateDbg
);

  localparam logic [3:0] MAX_BITS = 4'(DATA_WIDTH);

  uartTxState_t          state;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic [DATA_WIDTH-1:0] bufferData;
  logic                  bufferFull;
  logic [3:0]            bitCnt;
  logic                  stopCnt;

  // Frame parameters latched at frame start.
  logic [3:0]            effBitsQ;
  logic                  parityEnQ;
  logic                  parityBitQ;
  logic                  twoStopQ;
  logic [DIV_WIDTH-1:0]  divisorQ;
  logic [4:0]            overSamplingQ;
`ifdef UART_TX_ERROR_INJECTION_EN
  logic                  injFramingQ;
  logic                  injBreakQ;
`endif

  logic                  txReady;
  logic                  accept;
  logic                  bitTick;
  logic                  inFrame;
  logic                  frameEnd;
  logic                  frameStart;
  logic [DATA_WIDTH-1:0] nextWord;
  logic [DATA_WIDTH-1:0] newMask;
  logic [3:0]            newBits;
  logic                  newParity;
  logic                  lineNext;

  assign txReady      = (state != RESET) && !bufferFull;
  assign txIf.txReady = txReady;
  assign accept       = txIf.txValid && txReady;
  assign stateDbg     = state;

  always_comb begin
    inFrame = 1'b0;
    case (state)
      STARTBIT, DATA, PARITYBIT, STOPBIT: inFrame = 1'b1;
      default:                            inFrame = 1'b0;
    endcase
  end

  // This is the last cycle of the last stop bit as the FSM sees it.
  // On the tx pin it appears one cycle later.
  assign frameEnd = (state == STOPBIT) && bitTick && (stopCnt == twoStopQ);

  // A new frame starts from IDLE, or directly off the end of the current frame so that no idle
  // cycle is inserted. A word accepted on the end edge with an empty buffer goes straight out.
  assign frameStart = ((state == IDLE) && (accept || bufferFull)) ||
                      (frameEnd && (accept || bufferFull));
  assign nextWord   = bufferFull ? bufferData : txIf.txData;

  always_comb begin
    newBits = clampDataBits(cfgDataBits, MAX_BITS);
    newMask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      newMask[i] = (i < int'(newBits));
    end
    // XOR of the sent bits gives the even-parity bit. Odd parity inverts it.
    newParity = (^(nextWord & newMask)) ^ cfgParityOdd;
`ifdef UART_TX_ERROR_INJECTION_EN
    newParity = newParity ^ injectParityError;
`endif
  end

  always_comb begin
    lineNext = STOP_BIT;
    case (state)
      STARTBIT:  lineNext = START_BIT;
      DATA:      lineNext = shiftReg[0];
      PARITYBIT: lineNext = parityBitQ;
      STOPBIT:   lineNext = STOP_BIT;
      default:   lineNext = STOP_BIT;
    endcase
`ifdef UART_TX_ERROR_INJECTION_EN
    if (injFramingQ && (state == STOPBIT) && (stopCnt == 1'b0)) begin
      lineNext = 1'b0;
    end
    if (injBreakQ && inFrame) begin
      lineNext = 1'b0;
    end
`endif
  end

  uart_baud_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) baudTickGen (
    .clk          (clk),
    .reset        (reset),
    .clear        (frameStart),
    .enable       (inFrame),
    .divisor      (divisorQ),
    .overSampling (overSamplingQ),
    .bitTick      (bitTick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RESET;
      shiftReg      <= '0;
      bufferData    <= '0;
      bufferFull    <= 1'b0;
      bitCnt        <= '0;
      stopCnt       <= 1'b0;
      effBitsQ      <= MIN_DATA_BITS;
      parityEnQ     <= 1'b0;
      parityBitQ    <= 1'b0;
      twoStopQ      <= 1'b0;
      divisorQ      <= '0;
      overSamplingQ <= OVERSAMPLING_16;
`ifdef UART_TX_ERROR_INJECTION_EN
      injFramingQ   <= 1'b0;
      injBreakQ     <= 1'b0;
`endif
      tx            <= STOP_BIT;
      busy          <= 1'b0;
      frameDone     <= 1'b0;
    end else begin
      tx        <= lineNext;
      busy      <= inFrame;
      frameDone <= frameEnd;

      case (state)
        RESET: state <= IDLE;
        STARTBIT: begin
          if (bitTick) begin
            state  <= DATA;
            bitCnt <= '0;
          end
        end
        DATA: begin
          if (bitTick) begin
            shiftReg <= shiftReg >> 1;
            if (bitCnt == effBitsQ - 4'd1) begin
              state   <= parityEnQ ? PARITYBIT : STOPBIT;
              stopCnt <= 1'b0;
            end else begin
              bitCnt <= bitCnt + 4'd1;
            end
          end
        end
        PARITYBIT: begin
          if (bitTick) begin
            state   <= STOPBIT;
            stopCnt <= 1'b0;
          end
        end
        STOPBIT: begin
          if (bitTick) begin
            if (frameEnd) begin
              state <= IDLE;
            end else begin
              stopCnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Holding buffer. When it drains on the same edge that a new word is accepted,
      // the new word takes its place and the buffer stays full.
      if (frameStart) begin
        if (bufferFull) begin
          bufferFull <= accept;
          if (accept) begin
            bufferData <= txIf.txData;
          end
        end
      end else if (accept) begin
        bufferFull <= 1'b1;
        bufferData <= txIf.txData;
      end

      // Frame start overrides the next state chosen by the case statement above.
      if (frameStart) begin
        state         <= STARTBIT;
        shiftReg      <= nextWord;
        bitCnt        <= '0;
        stopCnt       <= 1'b0;
        effBitsQ      <= newBits;
        parityEnQ     <= cfgParityEnable;
        parityBitQ    <= newParity;
        twoStopQ      <= cfgTwoStop;
        divisorQ      <= cfgBaudDivisor;
        overSamplingQ <= cfgOverSampling;
`ifdef UART_TX_ERROR_INJECTION_EN
        injFramingQ   <= injectFramingError;
        injBreakQ     <= injectBreak;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// tb_uart_tx_frame_engine: directed and randomized frames against a per-cycle reference stream.
// For each accepted word, the reference model builds the list of line levels that make up the
// frame. It expands the list into one expected sample per clk cycle.
module tb_uart_tx_frame_engine;
  import UartGlobalPkg::*;

  localparam int DW   = 8;
  localparam int DIVW = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt++;

  // ---------------- DUT ----------------
  uart_tx_frame_engine_if #(.DATA_WIDTH(DW)) txIf();

  logic [3:0]      cfgDataBits;
  logic            cfgParityEnable;
  logic            cfgParityOdd;
  logic            cfgTwoStop;
  logic [DIVW-1:0] cfgBaudDivisor;
  logic [4:0]      cfgOverSampling;
  logic            tx;
  logic            busy;
  logic            frameDone;
  uartTxState_t    stateDbg;
`ifdef UART_TX_ERROR_INJECTION_EN
  logic injectParityError  = 1'b0;
  logic injectFramingError = 1'b0;
  logic injectBreak        = 1'b0;
`endif

  uart_tx_frame_engine #(
    .DATA_WIDTH (DW),
    .DIV_WIDTH  (DIVW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .txIf               (txIf),
    .cfgDataBits        (cfgDataBits),
    .cfgParityEnable    (cfgParityEnable),
    .cfgParityOdd       (cfgParityOdd),
    .cfgTwoStop         (cfgTwoStop),
    .cfgBaudDivisor     (cfgBaudDivisor),
    .cfgOverSampling    (cfgOverSampling),
`ifdef UART_TX_ERROR_INJECTION_EN
    .injectParityError  (injectParityError),
    .injectFramingError (injectFramingError),
    .injectBreak        (injectBreak),
`endif
    .tx                 (tx),
    .busy               (busy),
    .frameDone          (frameDone),
    .stateDbg           (stateDbg)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } sample_t;

  sample_t expQ[$];
  int checkCnt = 0;
  int errCnt   = 0;

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCnt++;
    if (actual !== expected) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference model: frame = start, effective data bits LSB first, optional parity, stop bits.
  // Each bit lasts max(div,1)*os cycles.
  task automatic pushFrame(input logic [DW-1:0] data, input bit leadIdle);
    int      effBits;
    int      ones;
    int      period;
    int      stops;
    int      levels[$];
    sample_t s;
    effBits = int'(cfgDataBits);
    if (effBits < 5)  effBits = 5;
    if (effBits > DW) effBits = DW;
    ones = 0;
    for (int i = 0; i < effBits; i++) ones += int'(data[i]);
    period = ((cfgBaudDivisor == 0) ? 1 : int'(cfgBaudDivisor)) * int'(cfgOverSampling);
    stops  = cfgTwoStop ? 2 : 1;
    levels.push_back(0);
    for (int i = 0; i < effBits; i++) levels.push_back(int'(data[i]));
    if (cfgParityEnable) levels.push_back((ones + int'(cfgParityOdd)) % 2);
    for (int i = 0; i < stops; i++) levels.push_back(1);
`ifdef UART_TX_ERROR_INJECTION_EN
    if (injectParityError && cfgParityEnable) levels[1 + effBits] = 1 - levels[1 + effBits];
    if (injectFramingError) levels[1 + effBits + (cfgParityEnable ? 1 : 0)] = 0;
    if (injectBreak) foreach (levels[k]) levels[k] = 0;
`endif
    if (leadIdle) begin
      s = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
      expQ.push_back(s);
    end
    foreach (levels[k]) begin
      for (int c = 0; c < period; c++) begin
        s.tx   = levels[k][0];
        s.busy = 1'b1;
        s.done = (k == levels.size() - 1) && (c == period - 1);
        expQ.push_back(s);
      end
    end
  endtask

  // Monitor on the falling edge. The DUT changes on the rising edge, so the falling edge sees stable values.
  always @(negedge clk) begin
    sample_t s;
    if (expQ.size() > 0) s = expQ.pop_front();
    else                 s = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
    checkEq("tx", tx, s.tx);
    checkEq("busy", busy, s.busy);
    checkEq("frameDone", frameDone, s.done);
    if (reset) expQ.delete();
    else if (txIf.txValid && txIf.txReady) pushFrame(txIf.txData, expQ.size() == 0);
  end

  // ---------------- driver tasks ----------------
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [DW-1:0] data, output int acceptCycle);
    int n = 0;
    txIf.txValid = 1'b1;
    txIf.txData  = data;
    while (n < 3000) begin
      @(negedge clk);
      if (txIf.txReady === 1'b1) break;
      n++;
    end
    checkEq("acceptTimeout", n < 3000, 1);
    @(posedge clk);
    #1;
    acceptCycle  = cycleCnt;
    txIf.txValid = 1'b0;
  endtask

  task automatic waitDone(input int startCycle, output int lat);
    int n = 0;
    lat = -1;
    while (n < 5000) begin
      @(negedge clk);
      if (frameDone === 1'b1) begin
        lat = cycleCnt - startCycle;
        break;
      end
      n++;
    end
    stepCycle();
  endtask

  task automatic waitIdle();
    int n = 0;
    while (expQ.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkEq("idleTimeout", n < 5000, 1);
    stepCycle();
  endtask

  task automatic setCfg(input int bits, input bit parEn, input bit parOdd, input bit twoStop,
                        input int div, input logic [4:0] os);
    cfgDataBits     = 4'(bits);
    cfgParityEnable = parEn;
    cfgParityOdd    = parOdd;
    cfgTwoStop      = twoStop;
    cfgBaudDivisor  = DIVW'(div);
    cfgOverSampling = os;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1500000;
    $display("FAIL watchdog: got no end of test, expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int acc2;
    int lat;
    txIf.txValid = 1'b0;
    txIf.txData  = '0;
    setCfg(8, 0, 0, 0, 2, OVERSAMPLING_16);

    // reset values
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkEq("resetReady", txIf.txReady, 0);
    checkEq("resetState", stateDbg, RESET);
    checkEq("resetTx", tx, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    stepCycle();
    @(negedge clk);
    checkEq("idleReady", txIf.txReady, 1);
    checkEq("idleState", stateDbg, IDLE);
    stepCycle();

    // 8N1 0x55, divisor 2, oversample 16
    sendWord(8'h55, acc);
    waitDone(acc, lat);
    checkEq("lat55", lat, 320);
    waitIdle();

    // even and odd parity on 0xA7
    setCfg(8, 1, 0, 0, 1, OVERSAMPLING_13);
    sendWord(8'hA7, acc);
    waitIdle();
    setCfg(8, 1, 1, 0, 1, OVERSAMPLING_13);
    sendWord(8'hA7, acc);
    waitIdle();

    // back-to-back 0x12 then 0x34 with txValid held high
    setCfg(8, 0, 0, 0, 2, OVERSAMPLING_16);
    sendWord(8'h12, acc);
    sendWord(8'h34, acc2);
    @(negedge clk);
    checkEq("bufFullReady", txIf.txReady, 0);
    checkEq("secondAcceptCycle", acc2 - acc, 1);
    stepCycle();
    waitDone(acc, lat);
    checkEq("latFirst", lat, 320);
    waitDone(acc, lat);
    checkEq("latSecond", lat, 640);
    waitIdle();

    // 7 data bits, two stop bits, 0xFF
    setCfg(7, 0, 0, 1, 1, OVERSAMPLING_16);
    sendWord(8'hFF, acc);
    waitDone(acc, lat);
    checkEq("lat7E2", lat, 160);
    waitIdle();

    // reset during data bit 3
    setCfg(8, 0, 0, 0, 1, OVERSAMPLING_13);
    sendWord(8'hC3, acc);
    repeat (57) stepCycle();
    reset = 1'b1;
    stepCycle();
    @(negedge clk);
    checkEq("midResetTx", tx, 1);
    checkEq("midResetBusy", busy, 0);
    checkEq("midResetDone", frameDone, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) stepCycle();
    sendWord(8'h5A, acc);
    waitIdle();

`ifdef UART_TX_ERROR_INJECTION_EN
    setCfg(8, 0, 0, 0, 2, OVERSAMPLING_16);
    injectFramingError = 1'b1;
    sendWord(8'h00, acc);
    waitIdle();
    injectFramingError = 1'b0;
    injectBreak = 1'b1;
    sendWord(8'hA5, acc);
    waitDone(acc, lat);
    checkEq("latBreak", lat, 320);
    waitIdle();
    injectBreak = 1'b0;
    setCfg(8, 1, 0, 0, 1, OVERSAMPLING_13);
    injectParityError = 1'b1;
    sendWord(8'h3C, acc);
    waitIdle();
    injectParityError = 1'b0;
`endif

    // randomized frames: config changes only while idle
    for (int it = 0; it < 24; it++) begin
      setCfg($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3),
             ($urandom_range(0, 1) != 0) ? OVERSAMPLING_13 : OVERSAMPLING_16);
      sendWord(8'($urandom_range(0, 255)), acc);
      if ($urandom_range(0, 1) != 0) sendWord(8'($urandom_range(0, 255)), acc2);
      waitIdle();
    end

    repeat (5) stepCycle();
    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_engine.md
# uart_tx_frame_engine

Parametrised UART transmitter that serialises data words into asynchronous frames on a single serial output. The frame shape is set at run time: data bits, parity enable and type, stop-bit count, baud divisor and oversampling factor. A one-word holding buffer allows back-to-back frames with no idle gap. It sits between the stimulus/driver side (valid/ready word interface) and the serial line, using the frame states defined in UartGlobalPkg.

## Interface
Parameters:
- DATA_WIDTH, 8, width of the holding register; the maximum number of data bits per frame.
- DIV_WIDTH, 16, width of the baud divisor.

Ports:
- clk  input  1  single clock
- reset  input  1  synchronous, active-high reset
- txValid  input  1  word offered
- txReady  output  1  engine can accept a word
- txData  input  DATA_WIDTH  word to send; LSB is transmitted first
- cfgDataBits  input  4  data bits per frame (5..DATA_WIDTH)
- cfgParityEnable  input  1  when 1, a parity bit is inserted after the data bits
- cfgParityOdd  input  1  0 selects even parity, 1 selects odd parity
- cfgTwoStop  input  1  0 selects one stop bit, 1 selects two stop bits
- cfgBaudDivisor  input  DIV_WIDTH  clk cycles per oversample tick; 0 is treated as 1
- cfgOverSampling  input  5  oversample ticks per bit (13 or 16)
- tx  output  1  serial line; idles high
- busy  output  1  a frame is in progress
- frameDone  output  1  one-cycle pulse at the end of the last stop bit

## Operation
- States: RESET → IDLE → STARTBIT → DATA → PARITYBIT (only when parity is enabled) → STOPBIT → IDLE, or → STARTBIT when the buffer is full.
- Handshake: a word is accepted when txValid and txReady are both high at a clk edge. txReady = !bufferFull.
- Buffer: one entry. If the engine is in IDLE, an accepted word moves straight to the shift register. Otherwise it is held in the buffer until the current frame ends.
- Config sampling: all cfg* inputs are captured at the start of each frame. Changes during a frame affect only the next frame.
- Data bit count: cfgDataBits below 5 is treated as 5; above DATA_WIDTH it is clamped to DATA_WIDTH. Data bits above the effective count are ignored.
- Parity is computed over the effective data bits only.
  - Even parity: the parity bit makes the total number of 1s (data plus parity) even.
  - Odd parity: the parity bit makes the total number of 1s odd.
- Bit period = max(cfgBaudDivisor,1) × cfgOverSampling clk cycles. Implemented as a divisor counter plus a tick counter. A bit counter tracks data bits; a stop counter tracks stop bits.
- tx: 0 during the start bit, data bits LSB first, then parity (if enabled), then 1 for each stop bit.

## Timing
- Values during and after reset: tx=1, txReady=0, busy=0, frameDone=0, buffer empty, state RESET.
- The cycle after reset deasserts, the state is IDLE and txReady=1.
- Latency: a word accepted at edge N while idle drives tx low (start bit) from edge N+1.
- The frame lasts (1 + bits + parity + stops) × bit-period cycles.
- frameDone pulses high for the final cycle of the last stop bit.
- Back-to-back operation: if the buffer is full when frameDone fires, the next start bit begins on the following cycle. No extra idle cycle is inserted, and busy stays high.
- Accept and drain in the same cycle: if a new word is accepted in the same cycle the buffer drains into the shift register, the new word lands in the buffer and txReady stays low.
- Reset mid-frame: tx returns to 1 at the next edge, the frame is dropped, the buffer is cleared, and no frameDone is produced.

## Configuration
- UART_TX_ERROR_INJECTION_EN, when defined, adds three inputs: injectParityError, injectFramingError and injectBreak. All three are captured at frame start with the config.
  - injectParityError: the parity bit is inverted.
  - injectFramingError: the first stop bit is driven 0.
  - injectBreak: tx is held 0 for the whole frame, including the stop bits. frameDone still pulses.
- When the macro is undefined, the three ports do not exist and frames are always well-formed.

## Structure
- Add to UartGlobalPkg:
  - a state typedef RESET/IDLE/STARTBIT/DATA/PARITYBIT/STOPBIT, which generalises the per-bit BITn enum;
  - constants START_BIT and STOP_BIT;
  - the OVERSAMPLING_13/16 values.
- One sub-module, uart_baud_tick_gen: takes the divisor and oversampling count, and produces a one-cycle bitTick. It is cleared at frame start so every bit period is exact.

## Test plan
- cfgBaudDivisor=2, cfgOverSampling=16, 8N1, send 0x55 → tx pattern 0,1,0,1,0,1,0,1,0,1 with each level lasting 32 cycles. frameDone fires at cycle 320 after acceptance.
- 8 data bits, even parity, send 0xA7 (five 1s) → parity bit 1. Repeat with odd parity → parity bit 0.
- Send 0x12 then 0x34 back-to-back with txValid held high → the second word is accepted during the first frame, txReady=0 while the buffer is full, and the start bit of 0x34 immediately follows the stop bit of 0x12. Total 640 cycles with busy continuously high.
- cfgDataBits=7, cfgTwoStop=1, send 0xFF → 7 data bits of 1 then two stop bits, 10-bit frame. Bit 7 is not sent.
- Assert reset during data bit 3 → tx=1 at the next edge, busy=0, no frameDone. The next word after reset transmits correctly.
- With UART_TX_ERROR_INJECTION_EN: injectFramingError on 0x00 8N1 → the stop bit is sampled as 0. injectBreak → tx is low for 320 cycles and frameDone still pulses.
